mem_load_sequencer: RTL

MEM_LOAD_SEQUENCER -- requirements
Module: mem_load_sequencer

---
 rtl/mem_load_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer: issues one aligned memory read per load request, aligns
// the returned word by access size and address offset, and reports completion
// or abort with single-cycle pulses.
module mem_load_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic [31:0] load_addr,
    input  logic [1:0]  load_size_in,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_ready,
    input  logic [31:0] mem_data_in,
    output logic [31:0] memory_data_register_out,
    output logic [1:0]  set_load_size_control,
    output logic        load_done,
    output logic        load_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Counter value on which a READ without mem_ready gives up.
    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [7:0]  r_count;
    logic [31:0] r_mdr;
    logic [1:0]  r_size_ctl;
    logic        w_req_legal;
    logic        w_wait_expired;
    logic [31:0] w_aligned;

    // Legality is judged on the live request inputs so IDLE can branch to
    // READ or ERROR on the same edge that captures them.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_req_legal = 1'b0;
        unique case (load_size_in)
            SIZE_BYTE: w_req_legal = 1'b1;
            SIZE_HALF: w_req_legal = ~load_addr[0];
            SIZE_WORD: w_req_legal = (load_addr[1:0] == 2'b00);
            default:   w_req_legal = 1'b0;
        endcase
    end

    assign w_wait_expired = (r_count == LP_LAST_WAIT);

    // Right-justify the addressed byte/halfword of the memory word, zero-filled.
    always_comb begin
        w_aligned = mem_data_in;
        unique case (r_size)
            SIZE_BYTE: begin
                unique case (r_addr[1:0])
                    2'd0:    w_aligned = {24'h0, mem_data_in[7:0]};
                    2'd1:    w_aligned = {24'h0, mem_data_in[15:8]};
                    2'd2:    w_aligned = {24'h0, mem_data_in[23:16]};
                    default: w_aligned = {24'h0, mem_data_in[31:24]};
                endcase
            end
            SIZE_HALF: begin
                w_aligned = r_addr[1] ? {16'h0, mem_data_in[31:16]}
                                      : {16'h0, mem_data_in[15:0]};
            end
            default: w_aligned = mem_data_in;
        endcase
    end

    // Next-state logic; a mem_ready on the final wait cycle still completes.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (load_req) begin
                    w_next_state = w_req_legal ? S_READ : S_ERROR;
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    w_next_state = S_DONE;
                end else if (w_wait_expired) begin
                    w_next_state = S_ERROR;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERROR: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset forces IDLE asynchronously, abandoning any read.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and wait counter; both only move in IDLE/READ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= 32'h0;
            r_size  <= SIZE_WORD;
            r_count <= 8'h0;
        end else begin
            if (r_state == S_IDLE && load_req) begin
                r_addr  <= load_addr;
                r_size  <= load_size_in;
                r_count <= 8'h0;
            end else if (r_state == S_READ && !mem_ready && !w_wait_expired) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // Data register and its size tag update together and hold between loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mdr      <= 32'h0;
            r_size_ctl <= SIZE_WORD;
        end else if (r_state == S_READ && mem_ready) begin
            r_mdr      <= w_aligned;
            r_size_ctl <= r_size;
        end
    end

    // Outputs are registers or pure state decodes, isolated from memory inputs.
    assign mem_address              = {r_addr[31:2], 2'b00};
    assign mem_read                 = (r_state == S_READ);
    assign load_done                = (r_state == S_DONE);
    assign load_error               = (r_state == S_ERROR);
    assign busy                     = (r_state != S_IDLE);
    assign memory_data_register_out = r_mdr;
    assign set_load_size_control    = r_size_ctl;

endmodule
